// File: rtl/enc_pkg.sv
// Shared types and helpers for request_encoder: FSM state encoding, lowest-set-bit
// search and (with ENC_COUNT_EN) a population count.
package enc_pkg;

    typedef enum logic {ENC_IDLE = 1'b0, ENC_SERVE = 1'b1} enc_state_t;

    // Widest request vector the helpers support; callers zero-extend into this width.
    localparam int ENC_MAX_N = 64;
    localparam int ENC_IDX_W = 6;

    // Scans from the top down so the last hit written is the lowest set bit.
    function automatic logic [ENC_IDX_W-1:0] lowest_set_idx(input logic [ENC_MAX_N-1:0] vec);
        logic [ENC_IDX_W-1:0] result;
        result = '0;
        for (int i = ENC_MAX_N - 1; i >= 0; i--) begin
            result = vec[i] ? ENC_IDX_W'(i) : result;
        end
        return result;
    endfunction

`ifdef ENC_COUNT_EN
    function automatic logic [ENC_IDX_W:0] popcount(input logic [ENC_MAX_N-1:0] vec);
        logic [ENC_IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < ENC_MAX_N; i++) begin
            cnt = cnt + {{ENC_IDX_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction
`endif

endpackage

// File: rtl/request_encoder_lsb_find.sv
// Combinational lowest-set-bit finder: binary index, isolated one-hot bit and a
// flag for "exactly one bit set".
module lsb_find
    import enc_pkg::*;
#(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         single
);

    logic [ENC_MAX_N-1:0] vec_ext_s;

    // Zero-extend into the helper width, then decode index, isolated bit and single flag.
    always_comb begin
        vec_ext_s         = '0;
        vec_ext_s[N-1:0]  = vec;
        idx               = W'(lowest_set_idx(vec_ext_s));
        onehot            = vec & (~vec + {{(N-1){1'b0}}, 1'b1});
        single            = (vec != '0) && ((vec & (vec - {{(N-1){1'b0}}, 1'b1})) == '0);
    end

endmodule

// File: rtl/request_encoder.sv
// Serialises a latched request vector into binary indices, lowest first, one per
// idx handshake. Optional macro ENC_COUNT_EN adds the pend_cnt output.
module request_encoder
    import enc_pkg::*;
#(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [W-1:0] idx,
    output logic         idx_last
`ifdef ENC_COUNT_EN
    ,
    output logic [W:0]   pend_cnt
`endif
);

    enc_state_t   state_r;
    logic [N-1:0] pend_r;
    logic [W-1:0] idx_s;
    logic [N-1:0] onehot_s;
    logic         single_s;

    lsb_find #(.N(N)) u_lsb_find (
        .vec    (pend_r),
        .idx    (idx_s),
        .onehot (onehot_s),
        .single (single_s)
    );

    // FSM and pending-bit register; pend is zero whenever the FSM sits in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ENC_IDLE;
            pend_r  <= '0;
        end else begin
            case (state_r)
                ENC_IDLE: begin
                    if (req_valid && (req != '0)) begin
                        pend_r  <= req;
                        state_r <= ENC_SERVE;
                    end else begin
                        pend_r  <= '0;
                        state_r <= ENC_IDLE;
                    end
                end
                ENC_SERVE: begin
                    if (idx_ready) begin
                        pend_r  <= pend_r & ~onehot_s;
                        state_r <= single_s ? ENC_IDLE : ENC_SERVE;
                    end else begin
                        pend_r  <= pend_r;
                        state_r <= ENC_SERVE;
                    end
                end
                default: begin
                    pend_r  <= '0;
                    state_r <= ENC_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state and pend, never on inputs.
    always_comb begin
        req_ready = (state_r == ENC_IDLE);
        idx_valid = (state_r == ENC_SERVE);
        idx       = idx_s;
        idx_last  = (state_r == ENC_SERVE) && single_s;
    end

`ifdef ENC_COUNT_EN
    logic [ENC_MAX_N-1:0] pend_ext_s;

    // Popcount of the pending register; follows pend on the same edge.
    always_comb begin
        pend_ext_s        = '0;
        pend_ext_s[N-1:0] = pend_r;
        pend_cnt          = (W+1)'(popcount(pend_ext_s));
    end
`endif

endmodule
